// File: rtl/sprite_ram_arbiter.sv
// Single-port sprite-attribute RAM shared by the CPU bus and the scanline renderer.
// Renderer reads win every cycle it asserts ram_busy; one CPU write may be posted meanwhile.
module sprite_ram_arbiter #(
  parameter int unsigned AW       = 10,
  parameter int unsigned SW       = 6,
  parameter int unsigned SPR_BASE = 'h100
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [15:0]   cpu_addr,
  input  logic [15:0]   cpu_din,
  output logic [15:0]   cpu_dout,
  output logic          cpu_ack,
  output logic          cpu_hold,
  input  logic [SW-1:0] ram_addr,
  input  logic          ram_busy,
  output logic [15:0]   ram_data
);

  typedef enum logic {IDLE, RD_WAIT} state_t;

  localparam logic [AW-1:0] BASE = AW'(SPR_BASE);

  state_t        r_state, w_state_nxt;
  logic [15:0]   r_mem [0:(1<<AW)-1];
  logic [AW-1:0] w_ren_addr, w_cpu_addr, r_wbuf_addr;
  logic [15:0]   r_wbuf_data, r_rd_data, r_cpu_dout, r_ram_data;
  logic          r_wbuf_valid, r_cpu_ack;
  logic          w_wr_accept, w_rd_issue, w_mem_we;
  logic          w_unused_addr_hi;

  assign w_ren_addr       = BASE + AW'(ram_addr);
  assign w_cpu_addr       = cpu_addr[AW-1:0];
  assign w_unused_addr_hi = ^cpu_addr[15:AW];

  always_comb begin
    w_wr_accept = (r_state == IDLE) && cpu_req && cpu_we && !r_wbuf_valid && !r_cpu_ack;
    w_rd_issue  = (r_state == IDLE) && cpu_req && !cpu_we && !r_wbuf_valid && !ram_busy && !r_cpu_ack;
    // Drain only when the renderer leaves the port free; reset drops the buffered word.
    w_mem_we    = !reset && !ram_busy && r_wbuf_valid;
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_rd_issue) w_state_nxt = RD_WAIT;
      RD_WAIT: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (w_mem_we)   r_mem[r_wbuf_addr] <= r_wbuf_data;
    if (w_rd_issue) r_rd_data          <= r_mem[w_cpu_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ram_data <= '0;
    end else if (ram_busy) begin
      r_ram_data <= r_mem[w_ren_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cpu_ack    <= 1'b0;
      r_cpu_dout   <= '0;
      r_wbuf_valid <= 1'b0;
    end else begin
      r_cpu_ack <= w_wr_accept || (r_state == RD_WAIT);
      if (r_state == RD_WAIT) r_cpu_dout <= r_rd_data;
      if (w_mem_we) r_wbuf_valid <= 1'b0;
      if (w_wr_accept) begin
        r_wbuf_valid <= 1'b1;
        r_wbuf_addr  <= w_cpu_addr;
        r_wbuf_data  <= cpu_din;
      end
    end
  end

  assign cpu_ack  = r_cpu_ack;
  assign cpu_dout = r_cpu_dout;
  assign cpu_hold = cpu_req & ~r_cpu_ack;
  assign ram_data = r_ram_data;

endmodule

// File: tb/tb_sprite_ram_arbiter.sv
// Scoreboard bench for sprite_ram_arbiter: CPU completions are queued at issue
// and checked by an independent monitor; renderer data is checked inline.
module tb_sprite_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0, ram_busy = 1'b0;
  logic [15:0] cpu_addr = '0, cpu_din = '0;
  logic [5:0]  ram_addr = '0;
  logic [15:0] cpu_dout, ram_data;
  logic        cpu_ack, cpu_hold;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    bit          is_rd;
    logic [15:0] data;
    int          cyc;
    string       name;
  } exp_t;
  exp_t sb[$];

  sprite_ram_arbiter #(.AW(10), .SW(6), .SPR_BASE('h100)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_ack(cpu_ack), .cpu_hold(cpu_hold),
    .ram_addr(ram_addr), .ram_busy(ram_busy), .ram_data(ram_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] pat(input int i);
    if (i == 2) return 16'hABCD;
    return 16'h3C00 + 16'(i * 37);
  endfunction

  task automatic issue(input bit we, input logic [15:0] a, input logic [15:0] d,
                       input logic [15:0] exp_data, input int exp_cyc, input string name);
    exp_t e;
    e.is_rd = !we;
    e.data  = exp_data;
    e.cyc   = exp_cyc;
    e.name  = name;
    sb.push_back(e);
    cpu_req  = 1'b1;
    cpu_we   = we;
    cpu_addr = a;
    cpu_din  = d;
  endtask

  task automatic wait_ack(input string name);
    bit seen = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      seen = cpu_ack;
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: no cpu_ack within 200 cycles, required an ack", name);
    end
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d, input string name);
    issue(1'b1, a, d, 16'h0, cyc + 1, name);
    wait_ack(name);
  endtask

  task automatic rd(input logic [15:0] a, input logic [15:0] exp, input string name);
    issue(1'b0, a, 16'h0, exp, cyc + 2, name);
    wait_ack(name);
  endtask

  // Monitor: every completion must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (cpu_ack) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_ack: cpu_ack=1 at cycle %0d, required no ack", cyc);
      end else begin
        e = sb.pop_front();
        check({e.name, "_cyc"}, cyc, e.cyc);
        if (e.is_rd) check(e.name, cpu_dout, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, c, r;

    tick(3);
    check("rst_ack",  cpu_ack,  0);
    check("rst_dout", cpu_dout, 0);
    check("rst_rdat", ram_data, 0);
    check("rst_hold", cpu_hold, 0);
    reset = 1'b0;
    tick();

    wr(16'd5, 16'h1234, "wr_a5");
    rd(16'd5, 16'h1234, "rd_a5");
    wr(16'hFC05, 16'h7777, "wr_alias");
    rd(16'd5, 16'h7777, "rd_wrap");
    rd(16'h0405, 16'h7777, "rd_alias");
    wr(16'd7, 16'h0707, "wr_a7");

    for (int i = 0; i < 64; i++) wr(16'h0100 + 16'(i), pat(i), "wr_pre");

    ram_busy = 1'b1;
    ram_addr = 6'd2;
    tick();
    check("ren_abcd", ram_data, 16'hABCD);
    for (int i = 0; i < 64; i++) begin
      ram_addr = 6'(i);
      tick();
      check("ren_sweep", ram_data, pat(i));
    end
    ram_busy = 1'b0;
    tick(3);
    check("ren_hold", ram_data, pat(63));

    // Read held off by a 72-cycle renderer burst.
    ram_busy = 1'b1;
    ram_addr = 6'd5;
    b0 = cyc;
    tick(3);
    issue(1'b0, 16'd7, 16'h0, 16'h0707, b0 + 74, "rd_contend");
    repeat (69) begin
      tick();
      check("hold_rd", cpu_hold, 1);
    end
    ram_busy = 1'b0;
    wait_ack("rd_contend");

    // Posted write during busy, then a second write stuck behind it.
    ram_busy = 1'b1;
    ram_addr = 6'd4;
    tick();
    check("ren_pre", ram_data, pat(4));
    issue(1'b1, 16'h0104, 16'h5555, 16'h0, cyc + 1, "wr_posted");
    wait_ack("wr_posted");
    c = cyc;
    issue(1'b1, 16'h0105, 16'h6666, 16'h0, c + 7, "wr_held");
    repeat (5) begin
      tick();
      check("ren_old", ram_data, pat(4));
      check("hold_wr", cpu_hold, 1);
    end
    ram_busy = 1'b0;
    tick();
    ram_busy = 1'b1;
    ram_addr = 6'd4;
    tick();
    check("ren_drained", ram_data, 16'h5555);
    ram_busy = 1'b0;
    cpu_req  = 1'b0;
    tick();
    ram_busy = 1'b1;
    ram_addr = 6'd5;
    tick();
    check("ren_second", ram_data, 16'h6666);
    ram_busy = 1'b0;
    tick();

    // Read-after-write behind a posted write while the renderer is busy.
    ram_busy = 1'b1;
    ram_addr = 6'd0;
    tick();
    issue(1'b1, 16'd9, 16'hBEEF, 16'h0, cyc + 1, "wr_raw");
    wait_ack("wr_raw");
    r = cyc;
    issue(1'b0, 16'd9, 16'h0, 16'hBEEF, r + 7, "rd_raw");
    repeat (4) begin
      tick();
      check("hold_raw", cpu_hold, 1);
    end
    ram_busy = 1'b0;
    wait_ack("rd_raw");

    // Reset while a posted write is still buffered.
    ram_busy = 1'b1;
    ram_addr = 6'd10;
    tick();
    issue(1'b1, 16'h010A, 16'hDEAD, 16'h0, cyc + 1, "wr_drop");
    wait_ack("wr_drop");
    reset    = 1'b1;
    ram_busy = 1'b0;
    tick();
    check("rst2_ack",  cpu_ack,  0);
    check("rst2_dout", cpu_dout, 0);
    check("rst2_rdat", ram_data, 0);
    reset = 1'b0;
    tick(3);
    ram_busy = 1'b1;
    ram_addr = 6'd10;
    tick();
    check("dropped_write", ram_data, pat(10));
    ram_busy = 1'b0;
    tick();

    // Reset while in RD_WAIT: read is abandoned, no ack ever appears.
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 16'd5;
    tick();
    reset   = 1'b1;
    cpu_req = 1'b0;
    tick();
    check("rst3_ack",  cpu_ack,  0);
    check("rst3_rdat", ram_data, 0);
    reset = 1'b0;
    tick(3);
    check("rst3_noack", cpu_ack, 0);
    rd(16'd5, 16'h7777, "rd_post_reset");

    tick(3);
    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
